// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the multiplier front end.
//   - operand / product widths (only XLEN=32 is supported)
//   - mul_op encodings (2'b11 is reserved and behaves as MUL.W)
//   - Booth select struct and the radix-4 group decoder
package mul_pkg;

   localparam int XLEN   = 32;
   localparam int PROD_W = 2 * XLEN;
   localparam int PP_NUM = XLEN / 2 + 1;

   localparam logic [1:0] MUL_OP_W  = 2'b00;
   localparam logic [1:0] MUL_OP_H  = 2'b01;
   localparam logic [1:0] MUL_OP_HU = 2'b10;

   typedef struct packed {
      logic neg;
      logic one;
      logic two;
   } booth_sel_t;

   typedef struct packed {
      logic [1:0]      op;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
   } op_req_t;

   // (y[2i+1], y[2i], y[2i-1]) -> {neg, one, two}. 000/111 select zero, so
   // neg stays clear for them and the PP is a true all-zero row.
   function automatic booth_sel_t booth_decode(input logic [2:0] g);
      booth_sel_t s;
      s = '0;
      case (g)
         3'b001, 3'b010: s.one = 1'b1;
         3'b011:         s.two = 1'b1;
         3'b100:         begin s.two = 1'b1; s.neg = 1'b1; end
         3'b101, 3'b110: begin s.one = 1'b1; s.neg = 1'b1; end
         default:        s = '0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// booth_pp_gen: one radix-4 Booth partial-product slice.
//   grp  in   3      (y[2i+1], y[2i], y[2i-1])
//   x    in   33     sign/zero-extended multiplicand
//   pp   out  34     selected multiple (0, x, 2x), bitwise inverted when negative
//   neg  out  1      +1 owed at the slice LSB to finish the two's complement
module booth_pp_gen
   import mul_pkg::*;
(
   input  logic [2:0]      grp,
   input  logic [XLEN:0]   x,
   output logic [XLEN+1:0] pp,
   output logic            neg
);

   booth_sel_t       sel;
   logic [XLEN+1:0]  mag;

   always_comb begin
      sel = booth_decode(grp);
      mag = '0;
      if (sel.one)      mag = {x[XLEN], x};
      else if (sel.two) mag = {x, 1'b0};
      // inverting instead of negating keeps the carry chain out of this stage
      pp  = sel.neg ? ~mag : mag;
      neg = sel.neg;
   end

endmodule

// File: rtl/mul_booth_pp_stage.sv
// mul_booth_pp_stage: multiplier front end.
//   S1 registers {mul_op, src_a, src_b}; S2 registers the 17 Booth partial
//   products transposed into 64 columns of 17 bits for the column trees.
//   Two-stage valid/ready pipeline, throughput 1/cycle, latency 2, flush kills
//   both stages.
// Ports:
//   clk, reset (sync, active-high), flush
//   in_valid/in_ready, mul_op[1:0], src_a[31:0], src_b[31:0]
//   out_valid/out_ready, out_hi, pp_cols[1087:0] (column j at j*17 +: 17,
//   bit i = PP_i[j]), pp_neg[16:0]
// Build option: MUL_PP_OPERAND_ISOLATE_EN -- S1 loads zero on cycles where it
//   advances without an accepted op, so idle cycles do not toggle the Booth
//   logic and an idle S2 holds all-zero columns.
module mul_booth_pp_stage
   import mul_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               mul_op,
   input  logic [XLEN-1:0]          src_a,
   input  logic [XLEN-1:0]          src_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_hi,
   output logic [PROD_W*PP_NUM-1:0] pp_cols,
   output logic [PP_NUM-1:0]        pp_neg
);

   localparam int STAGES = 2;

   logic [STAGES:1]                 vld_pipe;   // [1]=S1, [2]=S2
   op_req_t                         s1_q;
   op_req_t                         in_req;
   logic                            s1_adv, s2_adv, accept;

   logic                            sign_op, ext_a, ext_b, hi_c;
   logic [XLEN:0]                   x33;
   logic [XLEN+2:0]                 y_pad;      // {y[33], y[32:0], y[-1]}
   logic [PP_NUM-1:0][XLEN+1:0]     slice;
   logic [PP_NUM-1:0][PROD_W-1:0]   pp_row;
   logic [PP_NUM-1:0]               neg_c;
   logic [PROD_W*PP_NUM-1:0]        cols_c;

   // ---------------- handshake ----------------
   assign s2_adv   = !vld_pipe[2] || out_ready;
   assign s1_adv   = !vld_pipe[1] || s2_adv;
   assign in_ready = s1_adv && !flush;
   assign accept   = in_valid && in_ready;
   assign in_req   = '{op: mul_op, a: src_a, b: src_b};

   // ---------------- operand extension ----------------
   // only MULH.WU is unsigned; the reserved code falls in with MUL.W
   assign sign_op = (s1_q.op != MUL_OP_HU);
   assign ext_a   = sign_op & s1_q.a[XLEN-1];
   assign ext_b   = sign_op & s1_q.b[XLEN-1];
   assign x33     = {ext_a, s1_q.a};
   assign y_pad   = {ext_b, ext_b, s1_q.b, 1'b0};
   assign hi_c    = (s1_q.op == MUL_OP_H) || (s1_q.op == MUL_OP_HU);

   // ---------------- Booth PP generation ----------------
   for (genvar i = 0; i < PP_NUM; i++) begin : g_pp
      booth_pp_gen u_pp (
         .grp (y_pad[2*i+2:2*i]),
         .x   (x33),
         .pp  (slice[i]),
         .neg (neg_c[i])
      );
      // sign-extend the slice to full product width, place at weight 2^(2i)
      assign pp_row[i] = {{(PROD_W-XLEN-2){slice[i][XLEN+1]}}, slice[i]} << (2*i);
   end

   // ---------------- transpose: row i bit j -> column j bit i ----------------
   for (genvar j = 0; j < PROD_W; j++) begin : g_col
      for (genvar i = 0; i < PP_NUM; i++) begin : g_bit
         assign cols_c[j*PP_NUM+i] = pp_row[i][j];
      end
   end

   // ---------------- pipeline registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe <= '0;
         s1_q     <= '0;
         out_hi   <= 1'b0;
         pp_cols  <= '0;
         pp_neg   <= '0;
      end else begin
         if (flush) begin
            vld_pipe <= '0;
         end else begin
            if (s1_adv) vld_pipe[1] <= accept;
            if (s2_adv) vld_pipe[2] <= vld_pipe[1];
         end
`ifdef MUL_PP_OPERAND_ISOLATE_EN
         // idle advances (and flushes) park S1 at zero; zero operands yield
         // all-zero PPs, so an idle S2 drains to zero as well
         if (s1_adv || flush) s1_q <= accept ? in_req : '0;
         if (s2_adv) begin
            out_hi  <= hi_c;
            pp_cols <= cols_c;
            pp_neg  <= neg_c;
         end
`else
         if (accept) s1_q <= in_req;
         if (s2_adv && vld_pipe[1]) begin
            out_hi  <= hi_c;
            pp_cols <= cols_c;
            pp_neg  <= neg_c;
         end
`endif
      end
   end

   assign out_valid = vld_pipe[2];

endmodule

// File: tb/tb_mul_booth_pp_stage.sv
// Bench for mul_booth_pp_stage: directed vector table, pipeline corner
// sequences (stall, flush, reset) and a random stream checked against an
// arithmetic Booth model through an in-order scoreboard.
module tb_mul_booth_pp_stage;
   import mul_pkg::*;

   localparam int CW = PROD_W * PP_NUM;

   logic              clk = 1'b0;
   logic              reset, flush, in_valid, in_ready, out_valid, out_ready, out_hi;
   logic [1:0]        mul_op;
   logic [31:0]       src_a, src_b;
   logic [CW-1:0]     pp_cols;
   logic [PP_NUM-1:0] pp_neg;

   mul_booth_pp_stage dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .mul_op(mul_op), .src_a(src_a), .src_b(src_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_hi(out_hi), .pp_cols(pp_cols), .pp_neg(pp_neg)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CW-1:0]     cols;
      logic [PP_NUM-1:0] neg;
      logic              hi;
   } exp_t;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a, b;
      logic [63:0] prod;
      logic        hi;
   } vec_t;

   int   checks = 0, failures = 0, n_out = 0;
   exp_t exp_q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   // Booth recoding from the arithmetic rules: digit d = -2*y[2i+1]+y[2i]+y[2i-1],
   // PP_i = d*x, with a negative PP stored as its one's complement (d*x-1)
   // and the missing +1 reported in neg_i.
   function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic        sa, sb;
      logic [63:0] xv, v, row;
      logic [34:0] yp;
      longint      x, d;
      sa = (op != 2'b10) && a[31];
      sb = (op != 2'b10) && b[31];
      xv = {{32{sa}}, a};
      x  = longint'(xv);
      yp = {sb, sb, b, 1'b0};
      e.cols = '0;
      e.neg  = '0;
      e.hi   = (op == 2'b01) || (op == 2'b10);
      for (int i = 0; i < PP_NUM; i++) begin
         d = -2 * longint'(yp[2*i+2]) + longint'(yp[2*i+1]) + longint'(yp[2*i]);
         v = d * x;
         if (d < 0) begin
            v = v - 64'd1;
            e.neg[i] = 1'b1;
         end
         row = v << (2*i);
         for (int j = 0; j < PROD_W; j++) e.cols[j*PP_NUM+i] = row[j];
      end
      return e;
   endfunction

   // weighted sum of every column bit plus the owed +1s (mod 2^64)
   function automatic logic [63:0] col_sum(input logic [CW-1:0] c, input logic [PP_NUM-1:0] n);
      logic [63:0] s;
      s = '0;
      for (int j = 0; j < PROD_W; j++)
         for (int i = 0; i < PP_NUM; i++)
            if (c[j*PP_NUM+i]) s = s + (64'd1 << j);
      for (int i = 0; i < PP_NUM; i++)
         if (n[i]) s = s + (64'd1 << (2*i));
      return s;
   endfunction

   // scoreboard: push on accept, pop/compare on output handshake
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_out", 64'd1, 64'd0);
            end else begin
               exp_t e;
               int   bad;
               e = exp_q.pop_front();
               bad = -1;
               for (int j = PROD_W-1; j >= 0; j--)
                  if (pp_cols[j*PP_NUM +: PP_NUM] !== e.cols[j*PP_NUM +: PP_NUM]) bad = j;
               checks++;
               if (bad >= 0) begin
                  failures++;
                  $display("FAIL sb_cols col=%0d act=%h exp=%h", bad,
                           pp_cols[bad*PP_NUM +: PP_NUM], e.cols[bad*PP_NUM +: PP_NUM]);
               end
               chk("sb_neg", 64'(pp_neg), 64'(e.neg));
               chk("sb_hi", 64'(out_hi), 64'(e.hi));
            end
         end
         if (flush) exp_q.delete();
         if (in_valid && in_ready) exp_q.push_back(model(mul_op, src_a, src_b));
      end
   end

   task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      in_valid = 1'b1; mul_op = op; src_a = a; src_b = b;
   endtask

   task automatic step;
      @(posedge clk); #1;
   endtask

   vec_t vt[8];

   initial begin
      logic [CW-1:0] snap;
      int            n0;
      logic [31:0]   corner[4];
      corner[0] = 32'h0; corner[1] = 32'hFFFF_FFFF;
      corner[2] = 32'h8000_0000; corner[3] = 32'h7FFF_FFFF;

      vt[0] = '{2'b00, 32'd3,          32'd5,          64'h0000_0000_0000_000F, 1'b0};
      vt[1] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001, 1'b1};
      vt[2] = '{2'b10, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 1'b1};
      vt[3] = '{2'b11, 32'd3,          32'd5,          64'h0000_0000_0000_000F, 1'b0};
      vt[4] = '{2'b00, 32'hFFFF_FFFF,  32'd5,          64'hFFFF_FFFF_FFFF_FFFB, 1'b0};
      vt[5] = '{2'b01, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, 1'b1};
      vt[6] = '{2'b01, 32'h7FFF_FFFF,  32'h8000_0000,  64'hC000_0000_8000_0000, 1'b1};
      vt[7] = '{2'b10, 32'h0,          32'hFFFF_FFFF,  64'h0,                   1'b1};

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      mul_op = 2'b00; src_a = '0; src_b = '0;
      repeat (3) step();
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_hi", 64'(out_hi), 64'd0);
      chk("rst_cols_zero", 64'(pp_cols == '0), 64'd1);
      chk("rst_neg", 64'(pp_neg), 64'd0);
      step();
      reset = 1'b0;
      step();

      // directed vectors: latency 2 and product invariant
      for (int k = 0; k < 8; k++) begin
         drive(vt[k].op, vt[k].a, vt[k].b);
         @(negedge clk);
         chk($sformatf("v%0d_in_ready", k), 64'(in_ready), 64'd1);
         step();
         in_valid = 1'b0;
         @(negedge clk);
         chk($sformatf("v%0d_lat1", k), 64'(out_valid), 64'd0);
         step();
         @(negedge clk);
         chk($sformatf("v%0d_lat2", k), 64'(out_valid), 64'd1);
         chk($sformatf("v%0d_sum", k), col_sum(pp_cols, pp_neg), vt[k].prod);
         chk($sformatf("v%0d_hi", k), 64'(out_hi), 64'(vt[k].hi));
         if (k == 2) begin
            chk("v2_neg16", 64'(pp_neg[16]), 64'd0);
            chk("v2_pp16_lsb", 64'(pp_cols[32*PP_NUM+16]), 64'd1);
         end
         step();
      end

      // back-to-back with downstream stall
      out_ready = 1'b0;
      drive(2'b00, 32'd7, 32'd9);               step();
      drive(2'b01, 32'h1234_5678, 32'h9ABC_DEF0); step();
      drive(2'b10, 32'hDEAD_BEEF, 32'h0BAD_F00D);
      @(negedge clk);
      chk("t4_full_out_valid", 64'(out_valid), 64'd1);
      chk("t4_in_ready_low", 64'(in_ready), 64'd0);
      snap = pp_cols;
      for (int c = 0; c < 2; c++) begin
         step();
         @(negedge clk);
         chk("t4_cols_hold", 64'(pp_cols == snap), 64'd1);
         chk("t4_in_ready_hold", 64'(in_ready), 64'd0);
      end
      step();
      n0 = n_out;
      out_ready = 1'b1;
      @(negedge clk);
      chk("t4_release_in_ready", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      repeat (4) step();
      chk("t4_out_count", 64'(n_out - n0), 64'd3);

      // flush with both stages full and a competing input
      drive(2'b00, 32'd11, 32'd13); step();
      drive(2'b00, 32'd17, 32'd19); step();
      flush = 1'b1;
      drive(2'b01, 32'hAAAA_AAAA, 32'h5555_5555);
      @(negedge clk);
      chk("t5_in_ready_flush", 64'(in_ready), 64'd0);
      step();
      flush = 1'b0;
      drive(2'b10, 32'h0001_0000, 32'h0002_0000);
      @(negedge clk);
      chk("t5_out_valid_killed", 64'(out_valid), 64'd0);
      chk("t5_in_ready_after", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t5_next_lat1", 64'(out_valid), 64'd0);
      step();
      @(negedge clk);
      chk("t5_next_lat2", 64'(out_valid), 64'd1);
      chk("t5_next_sum", col_sum(pp_cols, pp_neg), 64'h0000_0002_0000_0000);
      step();
      step();
      chk("t5_sb_empty", 64'(exp_q.size()), 64'd0);

      // reset while stalled full
      out_ready = 1'b0;
      drive(2'b01, 32'hFFFF_0001, 32'h8765_4321); step();
      drive(2'b00, 32'h0F0F_0F0F, 32'hF0F0_F0F0); step();
      in_valid = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("t6_out_valid", 64'(out_valid), 64'd0);
      chk("t6_cols_zero", 64'(pp_cols == '0), 64'd1);
      chk("t6_neg_zero", 64'(pp_neg), 64'd0);
      chk("t6_in_ready", 64'(in_ready), 64'd1);
      step();
      out_ready = 1'b1;

      // random stream against the scoreboard
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(3) != 0);
         flush     = ($urandom_range(29) == 0);
         mul_op    = 2'($urandom_range(3));
         src_a     = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : $urandom;
         src_b     = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : $urandom;
         step();
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (6) step();
      chk("rnd_drained", 64'(exp_q.size()), 64'd0);
      chk("rnd_idle_out_valid", 64'(out_valid), 64'd0);
`ifdef MUL_PP_OPERAND_ISOLATE_EN
      chk("iso_idle_cols_zero", 64'(pp_cols == '0), 64'd1);
      chk("iso_idle_neg_zero", 64'(pp_neg), 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
